toggle_bank: RTL and testbench

TOGGLE_BANK -- requirements
Module: toggle_bank

---
 rtl/toggle_bank_pkg.sv | 14 +
 rtl/toggle_chan.sv | 127 ++++++++++++
 rtl/toggle_bank.sv | 40 ++++
 tb/tb_toggle_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_bank_pkg.sv
// Shared definitions for the toggle_bank channel array: the channel mode
// encoding and its width.
package toggle_bank_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_PULSE  = 2'b11
    } mode_t;

endpackage

// File: rtl/toggle_chan.sv
// One toggle_bank channel: cycle counter, output flop, mode register and,
// when TOGGLE_BANK_EDGE_EN is defined, a rising-edge detector on the enable.
module toggle_chan
    import toggle_bank_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [CNT_W-1:0]  i_hp_m1,
    output logic              o_toggle,
    output logic              o_active
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_active;
    logic             w_active_nxt;
    mode_t            r_mode;
    mode_t            w_mode_in;
    logic             w_trig;
    logic             w_terminal;

    assign w_mode_in  = mode_t'(i_mode);
    // The >= compare also catches a half-period lowered below the running count.
    assign w_terminal = (r_cnt >= i_hp_m1);

`ifdef TOGGLE_BANK_EDGE_EN
    logic r_en_prev;

    // Enable history for rising-edge triggering in TOGGLE and PULSE modes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_en_prev <= 1'b0;
        end else begin
            r_en_prev <= i_en;
        end
    end

    assign w_trig = i_en & ~r_en_prev;
`else
    assign w_trig = i_en;
`endif

    // Next-state of one channel; a mode change only clears and holds for a cycle.
    always_comb begin
        w_cnt_nxt    = {CNT_W{1'b0}};
        w_out_nxt    = r_out;
        w_active_nxt = 1'b0;
        if (w_mode_in != r_mode) begin
            w_out_nxt = r_out;
        end else begin
            case (r_mode)
                MODE_HOLD: begin
                    w_out_nxt = r_out;
                end
                MODE_TOGGLE: begin
                    if (w_trig) begin
                        w_out_nxt = ~r_out;
                    end else begin
                        w_out_nxt = r_out;
                    end
                end
                MODE_BLINK: begin
                    if (i_en) begin
                        w_active_nxt = 1'b1;
                        if (w_terminal) begin
                            w_out_nxt = ~r_out;
                            w_cnt_nxt = {CNT_W{1'b0}};
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                    end
                end
                MODE_PULSE: begin
                    if (r_active) begin
                        if (w_terminal) begin
                            w_out_nxt = 1'b0;
                        end else begin
                            w_active_nxt = 1'b1;
                            w_cnt_nxt    = r_cnt + CNT_W'(1);
                        end
                    end else if (w_trig) begin
                        w_out_nxt    = 1'b1;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_out_nxt = r_out;
                    end
                end
                default: begin
                    w_out_nxt = r_out;
                end
            endcase
        end
    end

    // Channel state; reset beats clear, clear beats everything else.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_out    <= 1'b0;
            r_active <= 1'b0;
            r_mode   <= MODE_HOLD;
        end else if (i_clr) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_out    <= 1'b0;
            r_active <= 1'b0;
            r_mode   <= w_mode_in;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_active <= w_active_nxt;
            r_mode   <= w_mode_in;
        end
    end

    assign o_toggle = r_out;
    assign o_active = r_active;

endmodule

// File: rtl/toggle_bank.sv
// Bank of NCH independent toggle/blink/pulse channels sharing one half-period.
// Optional build macro TOGGLE_BANK_EDGE_EN: edge-triggered TOGGLE/PULSE enables.
module toggle_bank
    import toggle_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [NCH-1:0]        toggle_en,
    input  logic [MODE_W*NCH-1:0] mode,
    input  logic [CNT_W-1:0]      half_period,
    output logic [NCH-1:0]        o_toggle,
    output logic [NCH-1:0]        o_active
);

    logic [CNT_W-1:0] w_hp_m1;

    // Terminal count is eff_hp-1, with a zero half-period behaving as one cycle.
    assign w_hp_m1 = (half_period == {CNT_W{1'b0}}) ? {CNT_W{1'b0}}
                                                    : (half_period - CNT_W'(1));

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        toggle_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .i_rst    (rst),
            .i_clr    (clr),
            .i_en     (toggle_en[g]),
            .i_mode   (mode[MODE_W*g +: MODE_W]),
            .i_hp_m1  (w_hp_m1),
            .o_toggle (o_toggle[g]),
            .o_active (o_active[g])
        );
    end

endmodule

// File: tb/tb_toggle_bank.sv
// Scoreboard bench for toggle_bank: a behavioural model pushes the expected
// outputs per driven cycle; they are popped and compared one edge later.
module tb_toggle_bank;

    logic        clk;
    logic        rst, clr;
    logic [3:0]  en;
    logic [7:0]  mode;
    logic [15:0] hp;
    logic [3:0]  o_toggle, o_active;

    logic        s_rst = 1'b1;
    logic [0:0]  s_en1 = 1'b0;
    logic [1:0]  s_mode1 = 2'b00;
    logic [31:0] s_en32 = 32'd0;
    logic [63:0] s_mode32 = 64'd0;
    logic [3:0]  s_hp = 4'd15;
    logic [0:0]  s_tog1, s_act1;
    logic [31:0] s_tog32, s_act32;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] sb_q[$];
    logic [1:0] sq[$];

    logic [3:0] m_tog, m_act, m_prev;
    logic [1:0] m_mode [4];
    int         m_cnt  [4];

    toggle_bank #(.NCH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .toggle_en(en), .mode(mode),
        .half_period(hp), .o_toggle(o_toggle), .o_active(o_active)
    );

    toggle_bank #(.NCH(1), .CNT_W(4)) u_n1 (
        .clk(clk), .rst(s_rst), .clr(1'b0), .toggle_en(s_en1), .mode(s_mode1),
        .half_period(s_hp), .o_toggle(s_tog1), .o_active(s_act1)
    );

    toggle_bank #(.NCH(32), .CNT_W(4)) u_n32 (
        .clk(clk), .rst(s_rst), .clr(1'b0), .toggle_en(s_en32), .mode(s_mode32),
        .half_period(s_hp), .o_toggle(s_tog32), .o_active(s_act32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step(input logic a_rst, input logic a_clr, input logic [3:0] a_en,
                              input logic [7:0] a_mode, input logic [15:0] a_hp);
        int eff;
        eff = (a_hp == 16'd0) ? 1 : int'(a_hp);
        for (int ch = 0; ch < 4; ch++) begin
            logic [1:0] md;
            logic       e, trig;
            md = a_mode[2*ch +: 2];
            e  = a_en[ch];
`ifdef TOGGLE_BANK_EDGE_EN
            trig = e & ~m_prev[ch];
`else
            trig = e;
`endif
            if (a_rst) begin
                m_tog[ch] = 1'b0; m_act[ch] = 1'b0; m_cnt[ch] = 0;
                m_mode[ch] = 2'b00; m_prev[ch] = 1'b0;
            end else if (a_clr) begin
                m_tog[ch] = 1'b0; m_act[ch] = 1'b0; m_cnt[ch] = 0;
                m_mode[ch] = md; m_prev[ch] = e;
            end else begin
                if (md != m_mode[ch]) begin
                    m_cnt[ch] = 0; m_act[ch] = 1'b0;
                end else if (md == 2'b01) begin
                    if (trig) m_tog[ch] = ~m_tog[ch];
                end else if (md == 2'b10) begin
                    m_act[ch] = e;
                    if (!e) m_cnt[ch] = 0;
                    else if (m_cnt[ch] + 1 >= eff) begin
                        m_tog[ch] = ~m_tog[ch]; m_cnt[ch] = 0;
                    end else m_cnt[ch] = m_cnt[ch] + 1;
                end else if (md == 2'b11) begin
                    if (m_act[ch]) begin
                        if (m_cnt[ch] + 1 >= eff) begin
                            m_tog[ch] = 1'b0; m_act[ch] = 1'b0; m_cnt[ch] = 0;
                        end else m_cnt[ch] = m_cnt[ch] + 1;
                    end else if (trig) begin
                        m_tog[ch] = 1'b1; m_act[ch] = 1'b1; m_cnt[ch] = 0;
                    end
                end else begin
                    m_cnt[ch] = 0; m_act[ch] = 1'b0;
                end
                m_mode[ch] = md;
                m_prev[ch] = e;
            end
        end
    endtask

    task automatic step(input logic a_rst, input logic a_clr, input logic [3:0] a_en,
                        input logic [7:0] a_mode, input logic [15:0] a_hp);
        logic [7:0] want;
        rst = a_rst; clr = a_clr; en = a_en; mode = a_mode; hp = a_hp;
        model_step(a_rst, a_clr, a_en, a_mode, a_hp);
        sb_q.push_back({m_tog, m_act});
        @(posedge clk); #1;
        want = sb_q.pop_front();
        n_vec++;
        assert ({o_toggle, o_active} === want) else begin
            n_miss++;
            $error("FAIL step%0d tog/act observed=%b expected=%b", n_vec, {o_toggle, o_active}, want);
        end
    endtask

    localparam logic [7:0] M_RUN  = 8'b10_11_10_01;
    localparam logic [7:0] M_HOLD = 8'b00_11_10_01;

    initial begin : main
        int         flips;
        int         highs;
        logic       last;
        logic [7:0] cur_mode;
        logic [1:0] sexp;
        m_tog = 4'd0; m_act = 4'd0; m_prev = 4'd0;
        for (int i = 0; i < 4; i++) begin m_mode[i] = 2'b00; m_cnt[i] = 0; end
        rst = 1'b1; clr = 1'b0; en = 4'd0; mode = 8'd0; hp = 16'd3;

        step(1'b1, 1'b0, 4'd0, 8'd0, 16'd3);
        step(1'b1, 1'b1, 4'hF, M_RUN, 16'd3);
        n_vec++;
        assert ({o_toggle, o_active} === 8'd0) else begin
            n_miss++; $error("FAIL reset observed=%b expected=%b", {o_toggle, o_active}, 8'd0);
        end
        step(1'b0, 1'b0, 4'd0, M_RUN, 16'd3);

        // Channel 0 TOGGLE
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0001, M_RUN, 16'd3);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'b0000, M_RUN, 16'd3);
        n_vec++;
        assert (o_toggle[0] === 1'b1) else begin
            n_miss++; $error("FAIL toggle_hold observed=%b expected=%b", o_toggle[0], 1'b1);
        end

        // Channel 1 BLINK, half-period 3
        flips = 0; last = o_toggle[1];
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 4'b0010, M_RUN, 16'd3);
            if (o_toggle[1] !== last) flips++;
            last = o_toggle[1];
        end
        n_vec++;
        assert (flips === 4) else begin
            n_miss++; $error("FAIL blink_flips observed=%0d expected=%0d", flips, 4);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, M_RUN, 16'd3);

        // Channel 2 PULSE, half-period 4
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 4'b0100, M_RUN, 16'd4);
            if (i < 5 && o_toggle[2] === 1'b1) highs++;
        end
        n_vec++;
        assert (highs === 4) else begin
            n_miss++; $error("FAIL pulse_len observed=%0d expected=%0d", highs, 4);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'b0000, M_RUN, 16'd4);

        // Channel 3 BLINK at half-period 0, then HOLD
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b1000, M_RUN, 16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1000, M_HOLD, 16'd0);

        // Half-period lowered below the running count
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'b0010, M_HOLD, 16'd10);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0010, M_HOLD, 16'd2);

        // Reset, then clear, in the middle of a pulse; then both together
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'b0100, M_RUN, 16'd5);
        step(1'b1, 1'b0, 4'b0100, M_RUN, 16'd5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, M_RUN, 16'd5);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'b0100, M_RUN, 16'd5);
        step(1'b0, 1'b1, 4'b0100, M_RUN, 16'd5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, M_RUN, 16'd5);
        step(1'b0, 1'b0, 4'b1111, M_RUN, 16'd1);
        step(1'b1, 1'b1, 4'b1111, M_RUN, 16'd1);

        // Random traffic over all modes
        cur_mode = M_RUN;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) cur_mode[2*$urandom_range(0, 3) +: 2] = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)), cur_mode, 16'($urandom_range(0, 5)));
        end

        // NCH=1 and NCH=32 with CNT_W=4, half-period 15
        @(posedge clk); #1;
        s_rst = 1'b0; s_mode1 = 2'b10; s_mode32 = {32{2'b10}};
        @(posedge clk); #1;
        s_en1 = 1'b1; s_en32 = 32'hFFFF_FFFF;
        for (int k = 1; k <= 40; k++) begin
            sq.push_back({((k / 15) % 2 == 1), 1'b1});
            @(posedge clk); #1;
            sexp = sq.pop_front();
            n_vec++;
            assert ({s_tog1, s_act1} === sexp) else begin
                n_miss++; $error("FAIL nch1_k%0d observed=%b expected=%b", k, {s_tog1, s_act1}, sexp);
            end
            n_vec++;
            assert (s_tog32 === {32{sexp[1]}} && s_act32 === {32{sexp[0]}}) else begin
                n_miss++; $error("FAIL nch32_k%0d observed=%h/%h expected=%b", k, s_tog32, s_act32, sexp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
